// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU.
// Operands are taken as magnitudes, one multiplier bit is consumed per cycle, and the sign is applied at the end.
module mul_seq #(
    parameter int unsigned XLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned PRD_W = 2 * XLEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   acc_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              a_neg_c;
    logic              b_neg_c;
    logic [XLEN-1:0]   a_mag_c;
    logic [XLEN-1:0]   b_mag_c;
    logic [XLEN:0]     sum_c;
    logic [PRD_W-1:0]  prod_c;
    logic [PRD_W-1:0]  prod_s_c;

    // Operand sign handling: a is signed for MULH/MULHSU, b only for MULH.
    always_comb begin
        a_neg_c = ((op == 2'b01) || (op == 2'b10)) && a[XLEN-1];
        b_neg_c = (op == 2'b01) && b[XLEN-1];
        a_mag_c = a_neg_c ? (~a + XLEN'(1)) : a;
        b_mag_c = b_neg_c ? (~b + XLEN'(1)) : b;
    end

    // One iteration: add into the upper half with carry, then shift {acc, multiplier} right.
    always_comb begin
        sum_c    = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        prod_c   = {sum_c, mplier_q[XLEN-1:1]};
        prod_s_c = neg_q ? (~prod_c + PRD_W'(1)) : prod_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= op;
                        neg_q    <= a_neg_c ^ b_neg_c;
                        mcand_q  <= a_mag_c;
                        mplier_q <= b_mag_c;
                        acc_q    <= '0;
                        cnt_q    <= CNT_W'(XLEN - 1);
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q    <= sum_c[XLEN:1];
                    mplier_q <= {sum_c[0], mplier_q[XLEN-1:1]};
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        result    <= (op_q == 2'b00) ? prod_s_c[XLEN-1:0]
                                                     : prod_s_c[PRD_W-1:XLEN];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
